// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: glyph table, blank pattern and decode types.
// The glyph table is the single source of truth for both encode and decode sides.
package sevenseg_pkg;

    // All cathodes high: nothing lit.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs for 0..F, bit0=a ... bit6=g.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        CLS_HEX   = 2'd0,
        CLS_BLANK = 2'd1,
        CLS_INV   = 2'd2
    } seg_class_t;

    typedef struct packed {
        seg_class_t cls;
        logic [3:0] nibble;
    } seg_cand_t;

    // Encoder-side lookup, kept here so both directions share GLYPHS.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        return GLYPHS[value];
    endfunction

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// Combinational classifier: maps a 7-bit active-low segment pattern to
// {class, nibble}. Non-hex patterns always report nibble 0 so candidates
// compare consistently.
module sevenseg_glyph_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] pattern,
    output seg_cand_t  cand
);

    // Search the shared glyph table; anything not found and not blank is invalid.
    always_comb begin
        cand.cls    = CLS_INV;
        cand.nibble = 4'h0;
        if (pattern == SEG_BLANK) begin
            cand.cls = CLS_BLANK;
        end
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPHS[i]) begin
                cand.cls    = CLS_HEX;
                cand.nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Multiplexed seven-segment bus reader. Registers the bus, classifies each
// sample, and commits a digit only after STABLE_CNT consecutive identical
// samples on that digit. Sticky flags report invalid glyphs and overlapping
// anodes.
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     digit_blank,
    output logic [DIGITS-1:0]     pat_err,
    output logic                  multi_an_err,
    output logic                  upd
);

    localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int ZW    = $clog2(DIGITS + 1) + 1;
    localparam logic [3:0] STABLE = 4'(STABLE_CNT);
    localparam seg_cand_t CAND_RST = '{cls: CLS_HEX, nibble: 4'h0};

    logic [6:0]        seg_q;
    logic [DIGITS-1:0] an_q;
    seg_cand_t         dec;
    seg_cand_t         cand [DIGITS];
    logic [3:0]        cnt  [DIGITS];

    logic [ZW-1:0]     n_zero;
    logic [SEL_W-1:0]  sel;
    logic              single;
    logic              multi;
    logic              match;
    logic [3:0]        cnt_nxt;
    logic              commit;
    logic              changed;
    logic [3:0]        cur_hex;

    // Stage 0: capture the raw bus every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            seg_q <= seg_n;
            an_q  <= an_n;
        end
    end

    // Stage 1: classify the captured pattern.
    sevenseg_glyph_decode u_decode (
        .pattern (seg_q),
        .cand    (dec)
    );

    // Count active-low anodes and remember which one was selected.
    always_comb begin
        n_zero = '0;
        sel    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_q[i]) begin
                n_zero = n_zero + ZW'(1);
                sel    = SEL_W'(i);
            end
        end
    end

    // Next candidate count for the selected digit, commit decision and change detect.
    always_comb begin
        single  = (n_zero == ZW'(1));
        multi   = (n_zero > ZW'(1));
        match   = (dec == cand[sel]);
        cur_hex = hex_out[4*sel +: 4];
        if (!match) begin
            cnt_nxt = 4'd1;
        end else if (cnt[sel] >= STABLE) begin
            cnt_nxt = STABLE;
        end else begin
            cnt_nxt = cnt[sel] + 4'd1;
        end
        commit  = single && (cnt_nxt == STABLE);
        changed = 1'b0;
        case (dec.cls)
            CLS_HEX:   changed = !digit_valid[sel] || digit_blank[sel] ||
                                 (cur_hex != dec.nibble);
            CLS_BLANK: changed = digit_valid[sel] || !digit_blank[sel];
            default:   changed = digit_valid[sel] || digit_blank[sel];
        endcase
    end

    // Stage 1 state: per-digit candidates, committed outputs and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                cand[i] <= CAND_RST;
                cnt[i]  <= 4'd0;
            end
            hex_out      <= '0;
            digit_valid  <= '0;
            digit_blank  <= '0;
            pat_err      <= '0;
            multi_an_err <= 1'b0;
            upd          <= 1'b0;
        end else begin
            upd <= commit && changed;
            // Clear first so a same-cycle error event below takes priority.
            if (clr) begin
                pat_err      <= '0;
                multi_an_err <= 1'b0;
            end
            if (multi) begin
                multi_an_err <= 1'b1;
            end
            if (single) begin
                cand[sel] <= dec;
                cnt[sel]  <= cnt_nxt;
            end
            if (commit) begin
                case (dec.cls)
                    CLS_HEX: begin
                        hex_out[4*sel +: 4] <= dec.nibble;
                        digit_valid[sel]    <= 1'b1;
                        digit_blank[sel]    <= 1'b0;
                    end
                    CLS_BLANK: begin
                        digit_valid[sel] <= 1'b0;
                        digit_blank[sel] <= 1'b1;
                    end
                    default: begin
                        digit_valid[sel] <= 1'b0;
                        digit_blank[sel] <= 1'b0;
                        pat_err[sel]     <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Scoreboard bench for sevenseg_scan_decoder: expected display snapshots are
// queued as stimulus is driven and matched against every upd pulse.
module tb_sevenseg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        clr;
    logic [15:0] hex_out;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_blank;
    logic [3:0]  pat_err;
    logic        multi_an_err;
    logic        upd;

    int checks = 0;
    int errors = 0;

    // Snapshot {hex_out, digit_valid, digit_blank}
    typedef logic [23:0] snap_t;
    snap_t exp_q[$];
    snap_t obs_q[$];

    sevenseg_scan_decoder #(.DIGITS(4), .STABLE_CNT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_n        (seg_n),
        .an_n         (an_n),
        .clr          (clr),
        .hex_out      (hex_out),
        .digit_valid  (digit_valid),
        .digit_blank  (digit_blank),
        .pat_err      (pat_err),
        .multi_an_err (multi_an_err),
        .upd          (upd)
    );

    always #5 clk = ~clk;

    // Record the display state on every upd pulse, away from the active edge.
    always @(negedge clk) begin
        if (upd === 1'b1) obs_q.push_back({hex_out, digit_valid, digit_blank});
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_n  = an;
        seg_n = seg;
        cyc(n);
    endtask

    task automatic idle(input int n);
        an_n  = 4'hF;
        seg_n = 7'h7F;
        cyc(n);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clr   = 1'b0;
        seg_n = 7'h00;
        an_n  = 4'h0;
        cyc(2);
        checks++;
        if ({hex_out, digit_valid, digit_blank, pat_err, multi_an_err, upd} !== 33'h0) begin
            errors++;
            $display("FAIL reset_outputs got hex=%h v=%b b=%b pe=%b m=%b u=%b want all 0",
                     hex_out, digit_valid, digit_blank, pat_err, multi_an_err, upd);
        end
        rst_n = 1'b1;
        an_n  = 4'hF;
        cyc(6);
        checks++;
        if ({hex_out, digit_valid, digit_blank, pat_err, multi_an_err} !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle got hex=%h v=%b b=%b pe=%b m=%b want all 0",
                     hex_out, digit_valid, digit_blank, pat_err, multi_an_err);
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_upd got %0d pulses want 0", obs_q.size());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_single_digit;
        snap_t e, o;
        exp_q.push_back({16'h0002, 4'b0001, 4'b0000});
        an_n  = 4'b1110;
        seg_n = 7'h24;
        cyc(4);
        checks++;
        if (digit_valid !== 4'b0000) begin
            errors++;
            $display("FAIL single_early got valid=%b want 0000", digit_valid);
        end
        cyc(1);
        checks++;
        if (hex_out[3:0] !== 4'h2 || digit_valid !== 4'b0001) begin
            errors++;
            $display("FAIL single_commit got hex=%h v=%b want 2 0001", hex_out[3:0], digit_valid);
        end
        cyc(10);
        idle(2);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL single_upd_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single_snap got %h want %h", o, e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_round_robin;
        snap_t e, o;
        logic [6:0] rr_glyph [4] = '{7'h79, 7'h24, 7'h30, 7'h19};
        exp_q.push_back({16'h0001, 4'b0001, 4'b0000});
        exp_q.push_back({16'h0021, 4'b0011, 4'b0000});
        exp_q.push_back({16'h0321, 4'b0111, 4'b0000});
        exp_q.push_back({16'h4321, 4'b1111, 4'b0000});
        for (int r = 0; r < 4; r++) begin
            for (int d = 0; d < 4; d++) begin
                drive(~(4'b0001 << d), rr_glyph[d], 1);
            end
        end
        idle(2);
        checks++;
        if (hex_out !== 16'h4321 || digit_valid !== 4'b1111) begin
            errors++;
            $display("FAIL rr_final got hex=%h v=%b want 4321 1111", hex_out, digit_valid);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rr_upd_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rr_snap got %h want %h", o, e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_glitch_filter;
        snap_t e, o;
        exp_q.push_back({16'h432A, 4'b1111, 4'b0000});
        drive(4'b1110, 7'h08, 4);
        idle(2);
        drive(4'b1110, 7'h01, 1);
        drive(4'b1110, 7'h08, 1);
        idle(2);
        checks++;
        if (hex_out !== 16'h432A || digit_valid !== 4'b1111 || pat_err !== 4'b0000) begin
            errors++;
            $display("FAIL glitch_ignored got hex=%h v=%b pe=%b want 432A 1111 0000",
                     hex_out, digit_valid, pat_err);
        end
        exp_q.push_back({16'h432A, 4'b1110, 4'b0000});
        drive(4'b1110, 7'h01, 4);
        idle(2);
        checks++;
        if (pat_err !== 4'b0001 || digit_valid !== 4'b1110 || hex_out[3:0] !== 4'hA) begin
            errors++;
            $display("FAIL glitch_invalid got pe=%b v=%b hex0=%h want 0001 1110 A",
                     pat_err, digit_valid, hex_out[3:0]);
        end
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        checks++;
        if (pat_err !== 4'b0000) begin
            errors++;
            $display("FAIL glitch_clr got pe=%b want 0000", pat_err);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL glitch_upd_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL glitch_snap got %h want %h", o, e);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_multi_anode;
        drive(4'b1100, 7'h08, 1);
        idle(2);
        checks++;
        if (multi_an_err !== 1'b1 || hex_out !== 16'h432A || digit_valid !== 4'b1110) begin
            errors++;
            $display("FAIL multi_set got m=%b hex=%h v=%b want 1 432A 1110",
                     multi_an_err, hex_out, digit_valid);
        end
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        checks++;
        if (multi_an_err !== 1'b0) begin
            errors++;
            $display("FAIL multi_clr got m=%b want 0", multi_an_err);
        end
        drive(4'b1100, 7'h08, 1);
        clr  = 1'b1;
        an_n = 4'hF;
        cyc(1);
        clr = 1'b0;
        checks++;
        if (multi_an_err !== 1'b1) begin
            errors++;
            $display("FAIL multi_set_wins got m=%b want 1", multi_an_err);
        end
        idle(2);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL multi_no_upd got %0d pulses want 0", obs_q.size());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_blank_and_reset;
        snap_t e, o;
        exp_q.push_back({16'h432A, 4'b0110, 4'b1000});
        drive(4'b0111, 7'h7F, 4);
        idle(2);
        checks++;
        if (digit_blank !== 4'b1000 || digit_valid[3] !== 1'b0) begin
            errors++;
            $display("FAIL blank_commit got b=%b v=%b want 1000 0xxx", digit_blank, digit_valid);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL blank_upd_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL blank_snap got %h want %h", o, e);
            end
        end
        obs_q.delete();
        exp_q.delete();
        drive(4'b1101, 7'h30, 2);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        drive(4'b1101, 7'h30, 3);
        idle(2);
        checks++;
        if (digit_valid !== 4'b0000 || hex_out !== 16'h0000 || digit_blank !== 4'b0000) begin
            errors++;
            $display("FAIL reset_discard got v=%b hex=%h b=%b want 0000 0000 0000",
                     digit_valid, hex_out, digit_blank);
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_discard_upd got %0d pulses want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        seg_n = 7'h00;
        an_n  = 4'h0;
        test_reset();
        test_single_digit();
        test_round_robin();
        test_glitch_filter();
        test_multi_anode();
        test_blank_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
